// File: rtl/switch_pkg.sv
// Shared types and defaults for the buffered N-core vector switch.
package switch_pkg;

    localparam int unsigned DEF_CORE_SIZE = 4;
    localparam int unsigned DEF_WIDTH     = 16;
    localparam int unsigned DEF_DATA_BITS = 32;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_VEC_BITS  = DEF_WIDTH * DEF_DATA_BITS;
    localparam int unsigned DEF_PTR_BITS  = $clog2(DEF_DEPTH);
    localparam int unsigned DEF_CNT_BITS  = DEF_PTR_BITS + 1;

    typedef logic [DEF_VEC_BITS-1:0]          vec_t;
    typedef logic [$clog2(DEF_CORE_SIZE)-1:0] core_idx_t;

    // A core index is usable only if it names an attached core.
    function automatic logic idx_in_range(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/switch_pair_fifo.sv
// Single-writer, single-reader FIFO holding the queue for one (src,dst) pair.
module switch_pair_fifo
    import switch_pkg::*;
#(
    parameter int unsigned VEC_BITS = DEF_VEC_BITS,
    parameter int unsigned DEPTH    = DEF_DEPTH
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                push,
    input  logic                pop,
    input  logic [VEC_BITS-1:0] push_data,
    output logic                full,
    output logic                empty,
    output logic [VEC_BITS-1:0] head
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = PTR_BITS + 1;

    logic [VEC_BITS-1:0] mem [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [CNT_BITS-1:0] count_q;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; stale entries are never observable because reads are gated by empty.
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr_q] <= push_data;
    end

    assign full  = (count_q == CNT_BITS'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/buffered_switch.sv
// N-core point-to-point vector switch with a private FIFO per (src,dst) pair.
module buffered_switch
    import switch_pkg::*;
#(
    parameter int unsigned CORE_SIZE      = DEF_CORE_SIZE,
    parameter int unsigned WIDTH          = DEF_WIDTH,
    parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
    parameter int unsigned DEPTH          = DEF_DEPTH,
    parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [CORE_SIZE-1:0]            send_ready,
    input  logic [CORE_ADDR_SIZE-1:0]       send_core_idx [CORE_SIZE-1:0],
    input  logic [WIDTH*DATA_BITS-1:0]      send_data [CORE_SIZE-1:0],
    output logic [CORE_SIZE-1:0]            send_ok,
    input  logic [CORE_SIZE-1:0]            recv_request,
    input  logic [CORE_ADDR_SIZE-1:0]       recv_core_idx [CORE_SIZE-1:0],
    output logic [CORE_SIZE-1:0]            recv_ready,
    output logic [WIDTH*DATA_BITS-1:0]      recv_data [CORE_SIZE-1:0],
    output logic [CORE_SIZE-1:0]            idx_error
);

    localparam int unsigned VB = WIDTH * DATA_BITS;

    // FIFO matrices are indexed [src][dst].
    logic          full  [CORE_SIZE-1:0][CORE_SIZE-1:0];
    logic          empty [CORE_SIZE-1:0][CORE_SIZE-1:0];
    logic          push  [CORE_SIZE-1:0][CORE_SIZE-1:0];
    logic          pop   [CORE_SIZE-1:0][CORE_SIZE-1:0];
    logic [VB-1:0] head  [CORE_SIZE-1:0][CORE_SIZE-1:0];

    logic [CORE_SIZE-1:0] send_valid;
    logic [CORE_SIZE-1:0] send_full;
    logic [CORE_SIZE-1:0] recv_valid;
    logic [CORE_SIZE-1:0] recv_empty;
    logic [VB-1:0]        recv_head [CORE_SIZE-1:0];

    for (genvar s = 0; s < CORE_SIZE; s++) begin : g_src
        for (genvar d = 0; d < CORE_SIZE; d++) begin : g_dst
            switch_pair_fifo #(
                .VEC_BITS (VB),
                .DEPTH    (DEPTH)
            ) u_fifo (
                .clock     (clock),
                .reset     (reset),
                .push      (push[s][d]),
                .pop       (pop[s][d]),
                .push_data (send_data[s]),
                .full      (full[s][d]),
                .empty     (empty[s][d]),
                .head      (head[s][d])
            );
        end
    end

    // Send side: pick the addressed FIFO's full flag, grant, and steer the push.
    always_comb begin
        for (int s = 0; s < CORE_SIZE; s++) begin
            send_valid[s] = idx_in_range(32'(send_core_idx[s]), CORE_SIZE);
            send_full[s]  = 1'b1;
            for (int d = 0; d < CORE_SIZE; d++) begin
                if (send_core_idx[s] == CORE_ADDR_SIZE'(d)) send_full[s] = full[s][d];
            end
            send_ok[s] = !reset && send_ready[s] && send_valid[s] && !send_full[s];
            for (int d = 0; d < CORE_SIZE; d++) begin
                push[s][d] = send_ok[s] && (send_core_idx[s] == CORE_ADDR_SIZE'(d));
            end
        end
    end

    // Receive side: select the requested source FIFO, grant, zero data when not granted.
    always_comb begin
        for (int r = 0; r < CORE_SIZE; r++) begin
            recv_valid[r] = idx_in_range(32'(recv_core_idx[r]), CORE_SIZE);
            recv_empty[r] = 1'b1;
            recv_head[r]  = '0;
            for (int s = 0; s < CORE_SIZE; s++) begin
                if (recv_core_idx[r] == CORE_ADDR_SIZE'(s)) begin
                    recv_empty[r] = empty[s][r];
                    recv_head[r]  = head[s][r];
                end
            end
            recv_ready[r] = !reset && recv_request[r] && recv_valid[r] && !recv_empty[r];
            recv_data[r]  = recv_ready[r] ? recv_head[r] : '0;
            for (int s = 0; s < CORE_SIZE; s++) begin
                pop[s][r] = recv_ready[r] && (recv_core_idx[r] == CORE_ADDR_SIZE'(s));
            end
        end
    end

    // Sticky per-core flag for any out-of-range index used with an active request.
    always_ff @(posedge clock) begin
        if (reset) idx_error <= '0;
        else       idx_error <= idx_error | (send_ready & ~send_valid)
                                          | (recv_request & ~recv_valid);
    end

endmodule

// File: tb/tb_buffered_switch.sv
// Directed bench for buffered_switch: a 4-core instance plus a 3-core instance for bad indices.
module tb_buffered_switch;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // 4-core instance
    logic [3:0]   s4_ready;
    logic [1:0]   s4_idx  [3:0];
    logic [511:0] s4_data [3:0];
    logic [3:0]   s4_ok;
    logic [3:0]   r4_req;
    logic [1:0]   r4_idx  [3:0];
    logic [3:0]   r4_ready;
    logic [511:0] r4_data [3:0];
    logic [3:0]   e4;

    // 3-core instance
    logic [2:0]   s3_ready;
    logic [1:0]   s3_idx  [2:0];
    logic [511:0] s3_data [2:0];
    logic [2:0]   s3_ok;
    logic [2:0]   r3_req;
    logic [1:0]   r3_idx  [2:0];
    logic [2:0]   r3_ready;
    logic [511:0] r3_data [2:0];
    logic [2:0]   e3;

    buffered_switch #(.CORE_SIZE(4)) u_dut4 (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (s4_ready),
        .send_core_idx (s4_idx),
        .send_data     (s4_data),
        .send_ok       (s4_ok),
        .recv_request  (r4_req),
        .recv_core_idx (r4_idx),
        .recv_ready    (r4_ready),
        .recv_data     (r4_data),
        .idx_error     (e4)
    );

    buffered_switch #(.CORE_SIZE(3)) u_dut3 (
        .clock         (clock),
        .reset         (reset),
        .send_ready    (s3_ready),
        .send_core_idx (s3_idx),
        .send_data     (s3_data),
        .send_ok       (s3_ok),
        .recv_request  (r3_req),
        .recv_core_idx (r3_idx),
        .recv_ready    (r3_ready),
        .recv_data     (r3_data),
        .idx_error     (e3)
    );

    // Lanes 1.0 .. 16.0 as IEEE-754 single bit patterns, built from integer arithmetic.
    function automatic logic [511:0] float_lanes();
        logic [511:0] v;
        int unsigned  e;
        logic [31:0]  mant;
        v = '0;
        for (int i = 0; i < 16; i++) begin
            int unsigned k;
            k = i + 1;
            e = 0;
            while ((k >> (e + 1)) != 0) e++;
            mant = (32'(k) << (23 - e)) & 32'h007F_FFFF;
            v[i*32 +: 32] = (32'(127 + e) << 23) | mant;
        end
        return v;
    endfunction

    // Distinct payload per (tag, n), each lane also distinct.
    function automatic logic [511:0] pat(input int tag, input int n);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = {8'(tag), 8'(n), 16'(i + 16'h5a00)};
        return v;
    endfunction

    task automatic idle();
        s4_ready = '0; r4_req = '0; s3_ready = '0; r3_req = '0;
        for (int i = 0; i < 4; i++) begin
            s4_idx[i] = '0; s4_data[i] = '0; r4_idx[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            s3_idx[i] = '0; s3_data[i] = '0; r3_idx[i] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic chk_bits(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        // Grants are masked while reset is held.
        s4_ready[0] = 1'b1; s4_idx[0] = 2'd1; s4_data[0] = pat(9, 9);
        #1;
        chk_bits("send_ok_in_reset", {3'b0, s4_ok[0]}, 4'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
        r4_req = 4'hf;
        #1;
        chk_bits("reset_recv_ready", r4_ready, 4'b0);
        chk_bits("reset_idx_err4", e4, 4'b0);
        chk_bits("reset_idx_err3", {1'b0, e3}, 4'b0);
        chk_vec("reset_recv_data", r4_data[0], '0);

        // 1: core0 -> core2, no same-cycle bypass, visible next cycle.
        next_cycle();
        s4_ready[0] = 1'b1; s4_idx[0] = 2'd2; s4_data[0] = float_lanes();
        r4_req[2] = 1'b1; r4_idx[2] = 2'd0;
        #1;
        chk_bits("t1_send_ok", s4_ok, 4'b0001);
        chk_bits("t1_no_bypass", {3'b0, r4_ready[2]}, 4'b0);
        next_cycle();
        r4_req[2] = 1'b1; r4_idx[2] = 2'd0;
        #1;
        chk_bits("t1_recv_ready", r4_ready, 4'b0100);
        chk_vec("t1_recv_data", r4_data[2], float_lanes());
        next_cycle();
        r4_req[2] = 1'b1; r4_idx[2] = 2'd0;
        #1;
        chk_bits("t1_drained", {3'b0, r4_ready[2]}, 4'b0);
        chk_vec("t1_data_zero", r4_data[2], '0);

        // 2: core1 sends 5 to core3 with no reader; only 4 fit.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            s4_ready[1] = 1'b1; s4_idx[1] = 2'd3; s4_data[1] = pat(1, k);
            #1;
            chk_bits("t2_send_ok", {3'b0, s4_ok[1]}, (k < 4) ? 4'b1 : 4'b0);
        end

        // 3: full pair, same-cycle push and pop: pop proceeds, push refused.
        next_cycle();
        s4_ready[1] = 1'b1; s4_idx[1] = 2'd3; s4_data[1] = pat(1, 9);
        r4_req[3] = 1'b1; r4_idx[3] = 2'd1;
        #1;
        chk_bits("t3_push_refused", {3'b0, s4_ok[1]}, 4'b0);
        chk_bits("t3_pop_ok", {3'b0, r4_ready[3]}, 4'b1);
        chk_vec("t3_pop_data", r4_data[3], pat(1, 0));
        next_cycle();
        s4_ready[1] = 1'b1; s4_idx[1] = 2'd3; s4_data[1] = pat(1, 9);
        #1;
        chk_bits("t3_retry_ok", {3'b0, s4_ok[1]}, 4'b1);
        next_cycle();
        s4_ready[1] = 1'b1; s4_idx[1] = 2'd3; s4_data[1] = pat(1, 10);
        #1;
        chk_bits("t3_full_again", {3'b0, s4_ok[1]}, 4'b0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            r4_req[3] = 1'b1; r4_idx[3] = 2'd1;
            #1;
            chk_bits("t3_drain_ready", {3'b0, r4_ready[3]}, 4'b1);
            chk_vec("t3_drain_data", r4_data[3], (k < 3) ? pat(1, k + 1) : pat(1, 9));
        end
        next_cycle();
        r4_req[3] = 1'b1; r4_idx[3] = 2'd1;
        #1;
        chk_bits("t3_empty", {3'b0, r4_ready[3]}, 4'b0);

        // 4: cores 0,1,2 -> core3 at once, plus core3 self-send.
        next_cycle();
        for (int s = 0; s < 3; s++) begin
            s4_ready[s] = 1'b1; s4_idx[s] = 2'd3; s4_data[s] = pat(10 + s, 0);
        end
        s4_ready[3] = 1'b1; s4_idx[3] = 2'd3; s4_data[3] = pat(7, 7);
        #1;
        chk_bits("t4_all_ok", s4_ok, 4'b1111);
        begin
            logic [1:0] order [4];
            order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; order[3] = 2'd3;
            for (int k = 0; k < 4; k++) begin
                next_cycle();
                r4_req[3] = 1'b1; r4_idx[3] = order[k];
                #1;
                chk_bits("t4_ready", {3'b0, r4_ready[3]}, 4'b1);
                chk_vec("t4_data", r4_data[3],
                        (order[k] == 2'd3) ? pat(7, 7) : pat(10 + int'(order[k]), 0));
            end
        end

        // 5: 3-core instance, out-of-range indices.
        next_cycle();
        s3_ready[0] = 1'b1; s3_idx[0] = 2'd3; s3_data[0] = pat(3, 3);
        s3_ready[1] = 1'b1; s3_idx[1] = 2'd2; s3_data[1] = pat(4, 4);
        #1;
        chk_bits("t5_send_ok", {1'b0, s3_ok}, 4'b0010);
        next_cycle();
        r3_req[2] = 1'b1; r3_idx[2] = 2'd1;
        r3_req[1] = 1'b1; r3_idx[1] = 2'd3;
        #1;
        chk_bits("t5_idx_err_set", {1'b0, e3}, 4'b0001);
        chk_bits("t5_recv_ready", {1'b0, r3_ready}, 4'b0100);
        chk_vec("t5_recv_data", r3_data[2], pat(4, 4));
        next_cycle();
        #1;
        chk_bits("t5_idx_err_sticky", {1'b0, e3}, 4'b0011);

        // 6: queue entries in several pairs, then pulse reset.
        next_cycle();
        s4_ready[0] = 1'b1; s4_idx[0] = 2'd1; s4_data[0] = pat(5, 0);
        s4_ready[2] = 1'b1; s4_idx[2] = 2'd3; s4_data[2] = pat(5, 2);
        next_cycle();
        s4_ready[0] = 1'b1; s4_idx[0] = 2'd1; s4_data[0] = pat(5, 1);
        next_cycle();
        reset = 1'b1;
        s4_ready[1] = 1'b1; s4_idx[1] = 2'd0; s4_data[1] = pat(6, 6);
        #1;
        chk_bits("t6_ok_in_reset", s4_ok, 4'b0);
        next_cycle();
        reset = 1'b0;
        r4_req[1] = 1'b1; r4_idx[1] = 2'd0;
        r4_req[3] = 1'b1; r4_idx[3] = 2'd2;
        r4_req[0] = 1'b1; r4_idx[0] = 2'd1;
        #1;
        chk_bits("t6_flushed", r4_ready, 4'b0);
        chk_bits("t6_idx_err_clr", {1'b0, e3}, 4'b0);
        next_cycle();
        s4_ready[1] = 1'b1; s4_idx[1] = 2'd0; s4_data[1] = pat(8, 1);
        #1;
        chk_bits("t6_new_send", s4_ok, 4'b0010);
        next_cycle();
        r4_req[0] = 1'b1; r4_idx[0] = 2'd1;
        #1;
        chk_bits("t6_new_recv", r4_ready, 4'b0001);
        chk_vec("t6_new_data", r4_data[0], pat(8, 1));

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
